fft_bitrev_unbundler: RTL

Output-side reorder stage of the parallel FFT datapath. It accepts DEPTH-wide complex bundles produced by the final butterfly stage, in which frame samples arrive in bit-reversed order. It buffers each frame of N samples in a ping-pong memory and emits the frame serially, one complex sample per cycle, in natural frequency order under a valid/ready handshake.

---
 rtl/fft_bitrev_unbundler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fft_bitrev_unbundler.sv
// Reorders bit-reversed DEPTH-wide FFT bundles into a natural-order serial stream via a ping-pong frame buffer.
// Latency: last bundle of a frame accepted at edge T -> sample k=0 valid after edge T+1; then one sample per cycle.
// Backpressure: in_ready drops while the write bank is full; the output register holds while out_valid && !out_ready.
module fft_bitrev_unbundler #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int N     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DEPTH*WIDTH-1:0]   din_R,
  input  logic [DEPTH*WIDTH-1:0]   din_Q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  dout_R,
  output logic signed [WIDTH-1:0]  dout_Q,
  output logic [$clog2(N)-1:0]     out_index,
  output logic                     out_last
);

  localparam int LOGN  = $clog2(N);
  localparam int LOGD  = $clog2(DEPTH);
  localparam int NB    = N / DEPTH;
  localparam int LOGNB = LOGN - LOGD;

  // Bit reversal of a frame index; the same map converts either way between position and bin.
  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] b;
    for (int i = 0; i < LOGN; i++) begin
      b[i] = a[LOGN-1-i];
    end
    return b;
  endfunction

  // Both banks live in one array; the top address bit selects the bank.
  logic [2*WIDTH-1:0] r_mem [0:2*N-1];

  logic [1:0]             r_full;
  logic                   r_wr_sel;
  logic                   r_rd_sel;
  logic [LOGNB-1:0]       r_wb;
  logic [LOGN-1:0]        r_rk;
  logic                   r_out_valid;
  logic signed [WIDTH-1:0] r_dout_R;
  logic signed [WIDTH-1:0] r_dout_Q;
  logic [LOGN-1:0]        r_out_index;
  logic                   r_out_last;

  logic                   w_acc;
  logic                   w_load;
  logic                   w_wr_done;
  logic                   w_rd_done;
  logic [LOGN:0]          w_rd_addr;
  logic [2*WIDTH-1:0]     w_rd_word;
  logic [1:0]             w_full_nxt;

  // in_ready comes only from registered state, so a bank freed this cycle is writable next cycle.
  assign in_ready  = !r_full[r_wr_sel];
  assign w_acc     = in_valid && in_ready;
  assign w_load    = r_full[r_rd_sel] && (!r_out_valid || out_ready);
  assign w_wr_done = w_acc && (r_wb == LOGNB'(NB - 1));
  assign w_rd_done = w_load && (r_rk == LOGN'(N - 1));
  assign w_rd_addr = {r_rd_sel, bitrev(r_rk)};
  assign w_rd_word = r_mem[w_rd_addr];

  assign out_valid = r_out_valid;
  assign dout_R    = r_dout_R;
  assign dout_Q    = r_dout_Q;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;

  // Full flags: set by the writer on its last bundle, cleared by the reader on its last sample.
  // The two never target the same bank in one cycle (set needs it empty, clear needs it full).
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_rd_done) w_full_nxt[r_rd_sel] = 1'b0;
  end

  // Frame buffer write: all lanes of an accepted bundle land at consecutive positions.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int l = 0; l < DEPTH; l++) begin
        r_mem[{r_wr_sel, r_wb, l[LOGD-1:0]}] <= {din_R[l*WIDTH +: WIDTH], din_Q[l*WIDTH +: WIDTH]};
      end
    end
  end

  // Write-side bundle counter and bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb     <= '0;
      r_wr_sel <= 1'b0;
    end else if (w_acc) begin
      r_wb <= r_wb + LOGNB'(1);
      if (w_wr_done) r_wr_sel <= ~r_wr_sel;
    end
  end

  // Read-side bin counter, bank pointer and bank occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk     <= '0;
      r_rd_sel <= 1'b0;
      r_full   <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_load) begin
        r_rk <= r_rk + LOGN'(1);
        if (w_rd_done) r_rd_sel <= ~r_rd_sel;
      end
    end
  end

  // Output register: loads the next natural-order bin, drops valid once consumed with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dout_R    <= '0;
      r_dout_Q    <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_dout_R    <= w_rd_word[2*WIDTH-1:WIDTH];
      r_dout_Q    <= w_rd_word[WIDTH-1:0];
      r_out_index <= r_rk;
      r_out_last  <= (r_rk == LOGN'(N - 1));
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
